switch_box_config_loader: RTL and testbench
===========================================

SWITCH_BOX_CONFIG_LOADER -- requirements
Module: switch_box_config_loader

Interface
REQ-001 SHALL have parameter CONF_WIDTH, default 96: width of the parallel configuration word sent to one switch box.
REQ-002 SHALL have parameter DW, default 8: width of one input chunk; CONF_WIDTH SHALL be an integer multiple of DW; NCHUNK = CONF_WIDTH/DW.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a configuration frame.
REQ-006 SHALL have port in_valid, input, 1: in_data holds a valid chunk.
REQ-007 SHALL have port in_data, input, DW: configuration chunk.
REQ-008 SHALL have port in_ready, output, 1: loader accepts a chunk this cycle.
REQ-009 SHALL have port c, output, CONF_WIDTH: configuration word for the switch box c input.
REQ-010 SHALL have port cset, output, 1: one-cycle load strobe for the switch box configuration register.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1: one-cycle pulse on successful commit.
REQ-013 SHALL have port err, output, 1: sticky frame-error flag.

Function
REQ-014 SHALL implement states IDLE, LOAD, CHECK, COMMIT.
REQ-015 IDLE: in_ready=0; start=1 -> LOAD, chunk counter cleared, err cleared, running checksum cleared.
REQ-016 LOAD: in_ready=1; chunk accepted iff in_valid && in_ready; accepted chunk shifts in from the MSB: c <= {in_data, c[CONF_WIDTH-1:DW]}; first chunk ends in c[DW-1:0].
REQ-017 LOAD: counter increments per accepted chunk; the NCHUNK-th acceptance -> CHECK when CFG_LOADER_CRC_EN is defined, else COMMIT.
REQ-018 COMMIT: cset=1 and done=1 for exactly one cycle, c stable and equal to the assembled word; next state IDLE.
REQ-019 cset SHALL assert the cycle immediately after the final accepted chunk (no CRC) and never at any other time.
REQ-020 c SHALL hold its last value in IDLE; c changes only on accepted chunks.
REQ-021 start outside IDLE SHALL be ignored; in_valid outside LOAD/CHECK SHALL be ignored.
REQ-022 in_valid low in LOAD SHALL stall without state change; no timeout.
REQ-023 busy, done, cset, in_ready SHALL be registered or decoded purely from state; no combinational path from in_valid to in_ready.

Reset
REQ-024 rst low SHALL immediately force: state IDLE, c=0, counter=0, checksum=0, cset=0, done=0, err=0, in_ready=0, busy=0.
REQ-025 Reset mid-frame SHALL discard the partial frame; no cset is produced for it.

Configuration
REQ-026 Macro CFG_LOADER_CRC_EN: when defined, a running XOR of all NCHUNK accepted chunks is kept; CHECK holds in_ready=1 and accepts one extra DW-bit checksum chunk.
REQ-027 With CFG_LOADER_CRC_EN, matching checksum -> COMMIT; mismatch -> IDLE with err=1, no cset, no done; err holds until next start or reset.
REQ-028 Without CFG_LOADER_CRC_EN: no CHECK state, no checksum logic, err tied to 0.

Verification
REQ-029 No CRC, defaults: start, then chunks 0x01..0x0C back-to-back -> cset=1 and done=1 one cycle after 12th accept; c=0x0C0B0A090807060504030201; busy low next cycle.
REQ-030 Same frame with in_valid low every other cycle -> identical c, cset exactly once, in_ready high throughout LOAD.
REQ-031 start pulsed after 5th chunk -> ignored; frame completes after 12 total chunks with same c.
REQ-032 rst low after 7th chunk -> all outputs 0 asynchronously; new full frame 0xFF x12 -> c all ones, one cset.
REQ-033 CRC_EN: chunks 0x01..0x0C then 0x0C (XOR) -> cset one cycle later; then with checksum 0x00 -> no cset, err=1 until next start.

Source files
------------

// File: rtl/switch_box_config_loader.sv
// Serial-to-parallel configuration loader for one switch box: assembles CONF_WIDTH bits from
// DW-bit chunks and strobes cset once per frame. Define CFG_LOADER_CRC_EN to add an XOR checksum stage.
module switch_box_config_loader #(
    parameter int unsigned CONF_WIDTH = 96,
    parameter int unsigned DW         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DW-1:0]         in_data,
    output logic                  in_ready,
    output logic [CONF_WIDTH-1:0] c,
    output logic                  cset,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned NCHUNK = CONF_WIDTH / DW;
    localparam int unsigned CNT_W  = $clog2(NCHUNK + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
`ifdef CFG_LOADER_CRC_EN
        CHECK  = 2'd2,
`endif
        COMMIT = 2'd3
    } state_t;

    state_t                  state_q;
    logic [CONF_WIDTH-1:0]   c_q, c_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    in_ready_q, busy_q, cset_q, done_q;
    logic                    accept;
`ifdef CFG_LOADER_CRC_EN
    logic [DW-1:0]           chk_q, chk_d;
    logic                    err_q;
`endif

    // New chunk enters at the top, so the first chunk of a frame ends up in the low DW bits.
    always_comb begin
        accept                  = in_valid && in_ready_q;
        c_d                     = c_q >> DW;
        c_d[CONF_WIDTH-1 -: DW] = in_data;
`ifdef CFG_LOADER_CRC_EN
        chk_d                   = chk_q ^ in_data;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            c_q        <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            cset_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
            chk_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            cset_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= LOAD;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
`ifdef CFG_LOADER_CRC_EN
                        chk_q      <= '0;
                        err_q      <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (accept) begin
                        c_q <= c_d;
`ifdef CFG_LOADER_CRC_EN
                        chk_q <= chk_d;
`endif
                        if (cnt_q == LAST_CNT) begin
                            cnt_q <= '0;
`ifdef CFG_LOADER_CRC_EN
                            state_q <= CHECK;
`else
                            state_q    <= COMMIT;
                            in_ready_q <= 1'b0;
                            cset_q     <= 1'b1;
                            done_q     <= 1'b1;
`endif
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
`ifdef CFG_LOADER_CRC_EN
                CHECK: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (in_data == chk_q) begin
                            state_q <= COMMIT;
                            cset_q  <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif
                COMMIT: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign c        = c_q;
    assign cset     = cset_q;
    assign busy     = busy_q;
    assign done     = done_q;
`ifdef CFG_LOADER_CRC_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Directed self-checking bench for switch_box_config_loader (default 96/8 geometry);
// the checksum scenarios are compiled in when CFG_LOADER_CRC_EN is defined.
module tb_switch_box_config_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [95:0] c;
    logic        cset;
    logic        busy;
    logic        done;
    logic        err;

    int checks;
    int errors;
    int cset_cnt;
    int cset_base;
    logic rdy_ok;

    localparam logic [95:0] EXP_A   = 96'h0C0B0A090807060504030201;
    localparam logic [95:0] EXP_MID = 96'h0605040302010C0B0A090807;
    localparam logic [95:0] EXP_FF  = 96'hFFFFFFFFFFFFFFFFFFFFFFFF;

    switch_box_config_loader #(
        .CONF_WIDTH(96),
        .DW        (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .c       (c),
        .cset    (cset),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cset === 1'b1) cset_cnt++;
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic start_frame(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy"}, {95'd0, busy}, 96'd1);
        chk({tag, "_ready"}, {95'd0, in_ready}, 96'd1);
    endtask

    // With the checksum stage present, the frame is only sealed by the extra chunk.
    task automatic seal(input logic [7:0] ck);
`ifdef CFG_LOADER_CRC_EN
        chk("check_ready", {95'd0, in_ready}, 96'd1);
        chk("check_no_cset", {95'd0, cset}, 96'd0);
        send(ck);
`else
        in_data = ck;
`endif
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cset_cnt = 0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst      = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_c", c, 96'd0);
        chk("rst_cset", {95'd0, cset}, 96'd0);
        chk("rst_done", {95'd0, done}, 96'd0);
        chk("rst_busy", {95'd0, busy}, 96'd0);
        chk("rst_ready", {95'd0, in_ready}, 96'd0);
        chk("rst_err", {95'd0, err}, 96'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        step();

        // in_valid while idle must not load anything
        send(8'h5A);
        chk("idle_ignore_c", c, 96'd0);
        chk("idle_ready", {95'd0, in_ready}, 96'd0);

        // back-to-back frame
        cset_base = cset_cnt;
        start_frame("f1");
        for (int i = 1; i <= 12; i++) begin
            send(8'(i));
            if (i < 12) chk("f1_no_early_cset", {95'd0, cset}, 96'd0);
        end
        seal(8'h0C);
        chk("f1_cset", {95'd0, cset}, 96'd1);
        chk("f1_done", {95'd0, done}, 96'd1);
        chk("f1_c", c, EXP_A);
        chk("f1_ready_commit", {95'd0, in_ready}, 96'd0);
        step();
        chk("f1_cset_drop", {95'd0, cset}, 96'd0);
        chk("f1_done_drop", {95'd0, done}, 96'd0);
        chk("f1_busy_low", {95'd0, busy}, 96'd0);
        chk("f1_c_hold", c, EXP_A);
        chk("f1_err", {95'd0, err}, 96'd0);
        chk("f1_cset_count", 96'(cset_cnt - cset_base), 96'd1);
        repeat (3) step();
        chk("f1_c_hold_idle", c, EXP_A);

        // stalled frame: in_valid low every other cycle
        cset_base = cset_cnt;
        rdy_ok    = 1'b1;
        start_frame("f2");
        for (int i = 1; i <= 12; i++) begin
            send(8'(i));
            if (i == 6) chk("f2_partial_c", c, EXP_MID);
            if (i < 12) begin
                if (in_ready !== 1'b1) rdy_ok = 1'b0;
                step();
                if (in_ready !== 1'b1) rdy_ok = 1'b0;
                if (cset !== 1'b0) rdy_ok = 1'b0;
            end
        end
        chk("f2_ready_throughout", {95'd0, rdy_ok}, 96'd1);
        seal(8'h0C);
        chk("f2_cset", {95'd0, cset}, 96'd1);
        chk("f2_c", c, EXP_A);
        step();
        step();
        chk("f2_cset_count", 96'(cset_cnt - cset_base), 96'd1);

        // start pulse mid-frame is ignored
        cset_base = cset_cnt;
        start_frame("f3");
        for (int i = 1; i <= 5; i++) send(8'(i));
        start = 1'b1;
        step();
        start = 1'b0;
        chk("f3_busy_after_start", {95'd0, busy}, 96'd1);
        chk("f3_ready_after_start", {95'd0, in_ready}, 96'd1);
        for (int i = 6; i <= 12; i++) begin
            send(8'(i));
            if (i < 12) chk("f3_no_early_cset", {95'd0, cset}, 96'd0);
        end
        seal(8'h0C);
        chk("f3_cset", {95'd0, cset}, 96'd1);
        chk("f3_c", c, EXP_A);
        step();
        chk("f3_busy_low", {95'd0, busy}, 96'd0);
        chk("f3_cset_count", 96'(cset_cnt - cset_base), 96'd1);

        // reset mid-frame, then a full frame of 0xFF
        cset_base = cset_cnt;
        start_frame("f4");
        for (int i = 1; i <= 7; i++) send(8'hA0 + 8'(i));
        #2 rst = 1'b0;
        #1;
        chk("midrst_c", c, 96'd0);
        chk("midrst_busy", {95'd0, busy}, 96'd0);
        chk("midrst_ready", {95'd0, in_ready}, 96'd0);
        chk("midrst_cset", {95'd0, cset}, 96'd0);
        chk("midrst_done", {95'd0, done}, 96'd0);
        chk("midrst_err", {95'd0, err}, 96'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step();
        chk("midrst_no_cset", 96'(cset_cnt - cset_base), 96'd0);
        start_frame("f5");
        for (int i = 1; i <= 12; i++) send(8'hFF);
        seal(8'h00);
        chk("f5_cset", {95'd0, cset}, 96'd1);
        chk("f5_c", c, EXP_FF);
        step();
        chk("f5_cset_count", 96'(cset_cnt - cset_base), 96'd1);

`ifdef CFG_LOADER_CRC_EN
        // bad checksum: no commit, sticky err until next start
        cset_base = cset_cnt;
        start_frame("f6");
        for (int i = 1; i <= 12; i++) send(8'(i));
        send(8'h00);
        chk("f6_err", {95'd0, err}, 96'd1);
        chk("f6_cset", {95'd0, cset}, 96'd0);
        chk("f6_done", {95'd0, done}, 96'd0);
        chk("f6_busy", {95'd0, busy}, 96'd0);
        repeat (3) step();
        chk("f6_err_sticky", {95'd0, err}, 96'd1);
        chk("f6_cset_count", 96'(cset_cnt - cset_base), 96'd0);
        start_frame("f7");
        chk("f7_err_cleared", {95'd0, err}, 96'd0);
        for (int i = 1; i <= 12; i++) send(8'(i));
        send(8'h0C);
        chk("f7_cset", {95'd0, cset}, 96'd1);
        chk("f7_c", c, EXP_A);
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
